// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: state encoding, access size codes and IO region decode.
// Used by mem_ctrl and mem_ctrl_arb (optional MEM_CTRL_RR_ARB_EN arbitration).
package mem_ctrl_pkg;

    localparam int IF_BLK_BYTES_DEF = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_IF_RD = 3'd1;
    localparam logic [2:0] ST_LS_RD = 3'd2;
    localparam logic [2:0] ST_LS_WR = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [1:0] {
        SZ_B    = 2'd0,
        SZ_H    = 2'd1,
        SZ_W    = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    // IO region: writes there honour io_buffer_full back-pressure.
    localparam int         IO_HI  = 17;
    localparam int         IO_LO  = 16;
    localparam logic [1:0] IO_SEL = 2'b11;

    localparam int GNT_IF  = 0;
    localparam int GNT_LSB = 1;

    // The reserved size code behaves as a word access.
    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input size_e sz);
        case (sz)
            SZ_B:    return 32'h0000_00FF;
            SZ_H:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Grant logic between instruction fetch and load/store buffer; one-hot grant output.
// MEM_CTRL_RR_ARB_EN selects round-robin on contention, otherwise fixed LSB-over-IF priority.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic       if_en,
    input  logic       lsb_en,
`ifdef MEM_CTRL_RR_ARB_EN
    input  logic       last_if,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (lsb_en && if_en) begin
`ifdef MEM_CTRL_RR_ARB_EN
            if (last_if) grant[GNT_LSB] = 1'b1;
            else         grant[GNT_IF]  = 1'b1;
`else
            grant[GNT_LSB] = 1'b1;
`endif
        end else if (lsb_en) begin
            grant[GNT_LSB] = 1'b1;
        end else if (if_en) begin
            grant[GNT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO bus controller serving fetch block refills and LSB loads/stores.
// Define MEM_CTRL_RR_ARB_EN for round-robin arbitration (adds the last-grant register).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int IF_BLK_BYTES = IF_BLK_BYTES_DEF,
    parameter int ADDR_W       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rob_clear,
    input  logic                      if_en,
    input  logic [ADDR_W-1:0]         if_addr,
    output logic                      if_done,
    output logic [8*IF_BLK_BYTES-1:0] if_data,
    input  logic                      lsb_en,
    input  logic                      lsb_wr,
    input  logic [ADDR_W-1:0]         lsb_addr,
    input  logic [1:0]                lsb_size,
    input  logic [31:0]               lsb_wdata,
    output logic                      lsb_done,
    output logic [31:0]               lsb_rdata,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [ADDR_W-1:0]         mem_a,
    output logic                      mem_wr,
    input  logic                      io_buffer_full
);

    localparam int CNT_W = $clog2(IF_BLK_BYTES) + 1;

    logic [2:0]                state;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          n_bytes;
    logic [ADDR_W-1:0]         addr_q;
    logic [ADDR_W-1:0]         cur_addr;
    logic [1:0]                size_q;
    logic [31:0]               wdata_q;
    logic                      sel_if;
    logic [8*IF_BLK_BYTES-1:0] blk_q;
    logic [8*IF_BLK_BYTES-1:0] blk_next;
    logic [1:0]                grant;
    logic                      take;
    logic                      rd_state;
    logic                      capture;
    logic                      rd_last;
    logic                      stall;

`ifdef MEM_CTRL_RR_ARB_EN
    logic last_if;

    mem_ctrl_arb u_arb (
        .if_en   (if_en),
        .lsb_en  (lsb_en),
        .last_if (last_if),
        .grant   (grant)
    );
`else
    mem_ctrl_arb u_arb (
        .if_en  (if_en),
        .lsb_en (lsb_en),
        .grant  (grant)
    );
`endif

    assign take     = (state == ST_IDLE) && !rob_clear && (grant != '0);
    assign n_bytes  = sel_if ? CNT_W'(IF_BLK_BYTES) : CNT_W'(size_bytes(size_e'(size_q)));
    assign cur_addr = addr_q + ADDR_W'(cnt);
    assign rd_state = (state == ST_IF_RD) || (state == ST_LS_RD);
    // Read data lags its address by one cycle, so byte cnt-1 arrives while cnt is driven.
    assign capture  = rd_state && (cnt != '0);
    assign rd_last  = rd_state && (cnt == n_bytes);
    assign stall    = (cur_addr[IO_HI:IO_LO] == IO_SEL) && io_buffer_full;

    always_comb begin
        blk_next = blk_q;
        for (int unsigned k = 0; k < IF_BLK_BYTES; k++) begin
            if (capture && (cnt == CNT_W'(k + 1))) blk_next[8*k +: 8] = mem_din;
        end
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if (rd_state && (cnt < n_bytes)) mem_a = cur_addr;
        if (state == ST_LS_WR) begin
            mem_a    = cur_addr;
            mem_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
            mem_wr   = rdy && !stall;
        end
    end

    assign if_done  = rdy && (state == ST_DONE) && sel_if;
    assign lsb_done = rdy && (state == ST_DONE) && !sel_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            sel_if    <= 1'b0;
            blk_q     <= '0;
            if_data   <= '0;
            lsb_rdata <= '0;
`ifdef MEM_CTRL_RR_ARB_EN
            last_if   <= 1'b1;
`endif
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        sel_if  <= grant[GNT_IF];
                        addr_q  <= grant[GNT_IF] ? if_addr : lsb_addr;
                        size_q  <= lsb_size;
                        wdata_q <= lsb_wdata;
                        cnt     <= '0;
`ifdef MEM_CTRL_RR_ARB_EN
                        last_if <= grant[GNT_IF];
`endif
                        if (grant[GNT_IF]) state <= ST_IF_RD;
                        else if (lsb_wr)   state <= ST_LS_WR;
                        else               state <= ST_LS_RD;
                    end
                end
                ST_IF_RD, ST_LS_RD: begin
                    if (rob_clear) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        if (capture) blk_q <= blk_next;
                        if (rd_last) begin
                            state <= ST_DONE;
                            if (sel_if) if_data <= blk_next;
                            else        lsb_rdata <= blk_next[31:0] & size_mask(size_e'(size_q));
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LS_WR: begin
                    if (!stall) begin
                        if (cnt == n_bytes - CNT_W'(1)) state <= ST_DONE;
                        else                            cnt   <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a one-cycle-latency RAM model and write log.
// Contention expectations follow MEM_CTRL_RR_ARB_EN when the bench is built with it.
module tb_mem_ctrl;

    logic         clk;
    logic         rst;
    logic         rdy;
    logic         rob_clear;
    logic         if_en;
    logic [31:0]  if_addr;
    logic         if_done;
    logic [511:0] if_data;
    logic         lsb_en;
    logic         lsb_wr;
    logic [31:0]  lsb_addr;
    logic [1:0]   lsb_size;
    logic [31:0]  lsb_wdata;
    logic         lsb_done;
    logic [31:0]  lsb_rdata;
    logic [7:0]   mem_din;
    logic [7:0]   mem_dout;
    logic [31:0]  mem_a;
    logic         mem_wr;
    logic         io_buffer_full;

    int           checks;
    int           errors;
    int           lat;
    logic [511:0] exp_blk;
    logic [39:0]  wr_log[$];
    logic [39:0]  exp_wr[$];

    mem_ctrl #(.IF_BLK_BYTES(64), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rob_clear      (rob_clear),
        .if_en          (if_en),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .lsb_en         (lsb_en),
        .lsb_wr         (lsb_wr),
        .lsb_addr       (lsb_addr),
        .lsb_size       (lsb_size),
        .lsb_wdata      (lsb_wdata),
        .lsb_done       (lsb_done),
        .lsb_rdata      (lsb_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: byte[a] = a[7:0], except 0x2002..0x2005 hold 11 22 33 44.
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (a >= 32'h2002 && a <= 32'h2005) return 8'h11 * 8'(a - 32'h2001);
        return a[7:0];
    endfunction

    always @(posedge clk) begin
        mem_din <= ram_rd(mem_a);
        if (mem_wr === 1'b1) wr_log.push_back({mem_a, mem_dout});
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit want_if, input int start, input int limit, output int c_done);
        c_done = -1;
        for (int c = start + 1; c <= start + limit; c++) begin
            @(negedge clk);
            if ((want_if ? if_done : lsb_done) === 1'b1) begin
                c_done = c;
                break;
            end
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, " count"}, 512'(wr_log.size()), 512'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check(tag, 512'(wr_log[i]), 512'(exp_wr[i]));
        wr_log.delete();
        exp_wr.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
        if_en = 1'b0; if_addr = '0;
        lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_wdata = '0;
        for (int k = 0; k < 64; k++) exp_blk[8*k +: 8] = 8'(k);
        repeat (2) @(negedge clk);
        check("reset if_done", 512'(if_done), 512'(0));
        check("reset lsb_done", 512'(lsb_done), 512'(0));
        check("reset mem_a", 512'(mem_a), 512'(0));
        check("reset mem_wr", 512'(mem_wr), 512'(0));
        check("reset if_data", if_data, 512'(0));
        check("reset lsb_rdata", 512'(lsb_rdata), 512'(0));
        rst = 1'b0;
        @(negedge clk);

        // IF refill at 0x1000: addresses step, done exactly 66 cycles after grant
        if_en = 1'b1; if_addr = 32'h1000;
        for (int j = 1; j <= 65; j++) begin
            @(negedge clk);
            if (j <= 64) check("if mem_a", 512'(mem_a), 512'(32'h1000 + 32'(j - 1)));
            check("if early done", 512'(if_done), 512'(0));
        end
        @(negedge clk);
        check("if_done pulse", 512'(if_done), 512'(1));
        check("if_data", if_data, exp_blk);
        if_en = 1'b0;
        @(negedge clk);
        check("if_done width", 512'(if_done), 512'(0));
        check("idle mem_a", 512'(mem_a), 512'(0));

        // Load word at 0x2002
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2002; lsb_size = 2'd2;
        @(negedge clk);
        check("ldw mem_a", 512'(mem_a), 512'(32'h2002));
        wait_done(1'b0, 1, 10, lat);
        check("ldw latency", 512'(lat), 512'(6));
        check("ldw rdata", 512'(lsb_rdata), 512'(32'h4433_2211));
        check("ldw if_data hold", if_data, exp_blk);
        lsb_en = 1'b0;
        @(negedge clk);
        check("ldw done width", 512'(lsb_done), 512'(0));

        // Load byte at 0x2005 and halfword at 0x2003
        lsb_en = 1'b1; lsb_addr = 32'h2005; lsb_size = 2'd0;
        wait_done(1'b0, 0, 10, lat);
        check("ldb latency", 512'(lat), 512'(3));
        check("ldb rdata", 512'(lsb_rdata), 512'(32'h0000_0044));
        lsb_en = 1'b0;
        @(negedge clk);
        lsb_en = 1'b1; lsb_addr = 32'h2003; lsb_size = 2'd1;
        wait_done(1'b0, 0, 10, lat);
        check("ldh latency", 512'(lat), 512'(4));
        check("ldh rdata", 512'(lsb_rdata), 512'(32'h0000_3322));
        lsb_en = 1'b0;
        @(negedge clk);

        // Store halfword 0xDEADBEEF at 0x0004
        wr_log.delete();
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h4; lsb_size = 2'd1; lsb_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("sth wr0", 512'(mem_wr), 512'(1));
        check("sth dout0", 512'(mem_dout), 512'(8'hEF));
        @(negedge clk);
        check("sth wr1", 512'(mem_wr), 512'(1));
        check("sth a1", 512'(mem_a), 512'(32'h5));
        @(negedge clk);
        check("sth done", 512'(lsb_done), 512'(1));
        check("sth done mem_wr", 512'(mem_wr), 512'(0));
        lsb_en = 1'b0;
        @(negedge clk);
        exp_wr.push_back({32'h4, 8'hEF});
        exp_wr.push_back({32'h5, 8'hBE});
        check_log("sth log");

        // IO stall: byte store to 0x30000 with io_buffer_full for three cycles
        io_buffer_full = 1'b1;
        lsb_en = 1'b1; lsb_addr = 32'h3_0000; lsb_size = 2'd0; lsb_wdata = 32'h0000_00A5;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            check("io stall mem_wr", 512'(mem_wr), 512'(0));
            check("io stall mem_a", 512'(mem_a), 512'(32'h3_0000));
        end
        @(negedge clk);
        io_buffer_full = 1'b0;
        #1;
        check("io release mem_wr", 512'(mem_wr), 512'(1));
        @(negedge clk);
        check("io done", 512'(lsb_done), 512'(1));
        lsb_en = 1'b0;
        @(negedge clk);
        exp_wr.push_back({32'h3_0000, 8'hA5});
        check_log("io log");

        // Flush IF refill at byte 10: no done, old block retained
        if_en = 1'b1; if_addr = 32'h1040;
        repeat (11) @(negedge clk);
        check("flush mem_a byte10", 512'(mem_a), 512'(32'h104A));
        rob_clear = 1'b1; if_en = 1'b0;
        @(negedge clk);
        check("flush idle mem_a", 512'(mem_a), 512'(0));
        check("flush mem_wr", 512'(mem_wr), 512'(0));
        rob_clear = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("flush no if_done", 512'(if_done), 512'(0));
            @(negedge clk);
        end
        check("flush if_data hold", if_data, exp_blk);

        // rob_clear together with a request in IDLE: no grant that cycle
        rob_clear = 1'b1;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2002; lsb_size = 2'd2;
        @(negedge clk);
        check("clear wins mem_a", 512'(mem_a), 512'(0));
        rob_clear = 1'b0;
        @(negedge clk);
        check("late grant mem_a", 512'(mem_a), 512'(32'h2002));
        wait_done(1'b0, 2, 10, lat);
        check("late grant latency", 512'(lat), 512'(7));
        lsb_en = 1'b0;
        @(negedge clk);

        // rob_clear during a word store: store completes
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h10; lsb_size = 2'd2; lsb_wdata = 32'h0102_0304;
        repeat (2) @(negedge clk);
        rob_clear = 1'b1;
        @(negedge clk);
        rob_clear = 1'b0;
        wait_done(1'b0, 3, 10, lat);
        check("stw flush latency", 512'(lat), 512'(5));
        lsb_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_wr.push_back({32'h10 + 32'(i), 8'(4 - i)});
        check_log("stw log");

        // rdy low mid-store: mem_wr forced low, mem_a held, no lost byte
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h20; lsb_size = 2'd1; lsb_wdata = 32'h0000_CAFE;
        @(negedge clk);
        check("rdy mem_wr before", 512'(mem_wr), 512'(1));
        rdy = 1'b0;
        #1;
        check("rdy low mem_wr", 512'(mem_wr), 512'(0));
        @(negedge clk);
        check("rdy low mem_a hold", 512'(mem_a), 512'(32'h20));
        rdy = 1'b1;
        @(negedge clk);
        check("rdy resume mem_a", 512'(mem_a), 512'(32'h21));
        @(negedge clk);
        check("rdy done", 512'(lsb_done), 512'(1));
        lsb_en = 1'b0;
        @(negedge clk);
        exp_wr.push_back({32'h20, 8'hFE});
        exp_wr.push_back({32'h21, 8'hCA});
        check_log("rdy log");

        // Contention from IDLE (last grant so far: LSB)
        if_en = 1'b1; if_addr = 32'h1000;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2005; lsb_size = 2'd0;
        @(negedge clk);
`ifdef MEM_CTRL_RR_ARB_EN
        check("contend first IF", 512'(mem_a), 512'(32'h1000));
        wait_done(1'b1, 1, 100, lat);
        check("contend IF latency", 512'(lat), 512'(66));
        if_en = 1'b0;
        wait_done(1'b0, lat, 10, lat);
        check("contend LSB latency", 512'(lat), 512'(70));
        lsb_en = 1'b0;
`else
        check("contend first LSB", 512'(mem_a), 512'(32'h2005));
        wait_done(1'b0, 1, 10, lat);
        check("contend LSB latency", 512'(lat), 512'(3));
        lsb_en = 1'b0;
        wait_done(1'b1, lat, 100, lat);
        check("contend IF latency", 512'(lat), 512'(70));
        if_en = 1'b0;
`endif
        check("contend rdata", 512'(lsb_rdata), 512'(32'h0000_0044));
        check("contend if_data", if_data, exp_blk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
